memory_cycle: RTL

//  Pipeline MEM stage, directly downstream of the execute stage. Consumes the E->M register outputs
//  and performs loads/stores over a req/ack data-memory port. Holds the pipeline via StallM while an

---
 rtl/memory_cycle_pkg.sv | 44 ++++
 rtl/memory_cycle_if.sv | 25 ++
 rtl/memory_cycle_access_ctrl.sv | 79 +++++++
 rtl/memory_cycle.sv | 105 ++++++++++
 4 files changed

// File: rtl/memory_cycle_pkg.sv
// Shared types and constants for the MEM pipeline stage: word width, access FSM states,
// and the RGB channel codes with their field offsets and masks.
package memory_pkg;

  localparam int WORD_W = 18;
  localparam int CH_W   = 6;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  localparam logic [1:0] RGB_FULL = 2'b00;
  localparam logic [1:0] RGB_R    = 2'b01;
  localparam logic [1:0] RGB_G    = 2'b10;
  localparam logic [1:0] RGB_B    = 2'b11;

  localparam logic [4:0] R_OFF = 5'd12;
  localparam logic [4:0] G_OFF = 5'd6;
  localparam logic [4:0] B_OFF = 5'd0;

  localparam logic [WORD_W-1:0] FULL_MASK = 18'h3FFFF;
  localparam logic [WORD_W-1:0] R_MASK    = 18'h3F000;
  localparam logic [WORD_W-1:0] G_MASK    = 18'h00FC0;
  localparam logic [WORD_W-1:0] B_MASK    = 18'h0003F;

  function automatic logic [WORD_W-1:0] chan_mask(input logic [1:0] rgb);
    case (rgb)
      RGB_R:   return R_MASK;
      RGB_G:   return G_MASK;
      RGB_B:   return B_MASK;
      default: return FULL_MASK;
    endcase
  endfunction

  function automatic logic [4:0] chan_off(input logic [1:0] rgb);
    case (rgb)
      RGB_R:   return R_OFF;
      RGB_G:   return G_OFF;
      default: return B_OFF;
    endcase
  endfunction

endpackage

// File: rtl/memory_cycle_if.sv
// Data-memory req/ack port. The MEM stage is the master; the memory (or a bench model) is the slave.
interface memory_cycle_if #(
  parameter int ADDR_W = 10
);
  import memory_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] wmask;
  logic              ack;
  logic [WORD_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata, wmask,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wmask,
    output ack, rdata
  );

endinterface

// File: rtl/memory_cycle_access_ctrl.sv
// Access sequencer for the MEM stage: IDLE/WAIT FSM, watchdog counter, request/stall/abort
// generation and the sticky timeout flag.
//   state | meaning
//   IDLE  | no access outstanding; a mem op requests this cycle and may complete zero-wait
//   WAIT  | request held, pipeline stalled until ack or watchdog abort
module mem_access_ctrl
  import memory_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_op,
  input  logic ack,
  output logic req,
  output logic stall,
  output logic abort,
  output logic err_timeout
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W:0] TO_VAL = (CNT_W+1)'(TIMEOUT);

  mem_state_t       state;
  mem_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_inc;

  // cnt_inc is the count including the current WAIT cycle; abort fires when it hits TIMEOUT
  assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        cnt <= '0;
      end else if (!ack && !abort && (TIMEOUT != 0)) begin
        cnt <= cnt_inc[CNT_W-1:0];
      end
      if (abort) begin
        err_timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_op && !ack) state_nxt = WAIT;
      WAIT:    if (ack || abort)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req   = 1'b0;
    stall = 1'b0;
    abort = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          req   = mem_op;
          stall = mem_op & ~ack;
        end
        WAIT: begin
          req   = 1'b1;
          abort = (TIMEOUT != 0) && !ack && (cnt_inc == TO_VAL);
          stall = ~ack & ~abort;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/memory_cycle.sv
// Pipeline MEM stage: drives the data-memory port, stalls upstream while an access is outstanding,
// and registers results into M->W. Optional RGB channel masking is enabled by MEMORY_RGB_MASK_EN.
module memory_cycle
  import memory_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              ResultSrcM,
  input  logic              BranchLinkM,
  input  logic [4:0]        RD_M,
  input  logic [WORD_W-1:0] PCPlus4M,
  input  logic [WORD_W-1:0] WriteDataM,
  input  logic [WORD_W-1:0] ALU_ResultM,
  input  logic [1:0]        RGB_M,
  input  logic [8:0]        PCM,
  memory_cycle_if.master    dmem,
  output logic              StallM,
  output logic              RegWriteW,
  output logic              ResultSrcW,
  output logic              BranchLinkW,
  output logic [4:0]        RD_W,
  output logic [WORD_W-1:0] ALU_ResultW,
  output logic [WORD_W-1:0] ReadDataW,
  output logic [WORD_W-1:0] PCPlus4W,
  output logic [8:0]        PCW,
  output logic              err_timeout
);

  logic              mem_op;
  logic              abort;
  logic [WORD_W-1:0] rdata_sel;

  assign mem_op = MemWriteM | ResultSrcM;

  mem_access_ctrl #(
    .TIMEOUT (TIMEOUT)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .mem_op      (mem_op),
    .ack         (dmem.ack),
    .req         (dmem.req),
    .stall       (StallM),
    .abort       (abort),
    .err_timeout (err_timeout)
  );

  assign dmem.we   = MemWriteM;
  assign dmem.addr = ALU_ResultM[ADDR_W-1:0];

`ifdef MEMORY_RGB_MASK_EN
  logic [WORD_W-1:0] ch_mask;
  logic [4:0]        ch_off;

  always_comb begin
    ch_mask = chan_mask(RGB_M);
    ch_off  = chan_off(RGB_M);
    if (RGB_M == RGB_FULL) begin
      dmem.wmask = FULL_MASK;
      dmem.wdata = WriteDataM;
      rdata_sel  = dmem.rdata;
    end else begin
      dmem.wmask = ch_mask;
      dmem.wdata = WORD_W'(WriteDataM[CH_W-1:0]) << ch_off;
      rdata_sel  = (dmem.rdata & ch_mask) >> ch_off;
    end
  end
`else
  logic unused_rgb;

  assign unused_rgb = ^RGB_M;
  assign dmem.wmask = FULL_MASK;
  assign dmem.wdata = WriteDataM;
  assign rdata_sel  = dmem.rdata;
`endif

  // A stalled cycle writes a full bubble so W never sees the instruction twice
  always_ff @(posedge clk) begin
    if (rst || StallM) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      BranchLinkW <= 1'b0;
      RD_W        <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
      PCPlus4W    <= '0;
      PCW         <= '0;
    end else begin
      RegWriteW   <= RegWriteM;
      ResultSrcW  <= ResultSrcM;
      BranchLinkW <= BranchLinkM;
      RD_W        <= RD_M;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= (mem_op && !abort) ? rdata_sel : '0;
      PCPlus4W    <= PCPlus4M;
      PCW         <= PCM;
    end
  end

endmodule
